serial_subtractor: RTL and testbench

- Bit-serial, LSB-first subtractor computing d = a - b and the final borrow out.
- Inverse arithmetic companion to the half adder: one half/full-subtractor cell is reused over WIDTH clock cycles, with a borrow flip-flop between cycles.
- Sits in the arithmetic lab datapath as a small-area subtract unit.
- Start/busy/done handshake to a controller or bench.

---
 rtl/serial_subtractor.sv | 113 +++++++++++
 tb/tb_serial_subtractor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: d = a - b over WIDTH cycles, reusing one
// full-subtractor cell with a borrow flop carried between bit positions.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             dbit,
    output logic             dvalid,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             done
);

    // Counter only has to reach WIDTH-1, but is sized for WIDTH so it never wraps.
    localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;

    logic x, y, diff, brn;
    logic [WIDTH-1:0] d_shift;

    always_comb begin
        x    = a_sr_q[0];
        y    = b_sr_q[0];
        diff = x ^ y ^ borrow_q;
        brn  = (~x & y) | (~(x ^ y) & borrow_q);
        // New difference bit enters at the MSB so d ends up in natural order.
        d_shift            = d_q >> 1;
        d_shift[WIDTH-1]   = diff;
    end

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        d_d      = d_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_SHIFT;
                    a_sr_d   = a;
                    b_sr_d   = b;
                    d_d      = '0;
                    cnt_d    = '0;
                    borrow_d = 1'b0;
                    bout_d   = 1'b0;
                end
            end
            S_SHIFT: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                d_d      = d_shift;
                borrow_d = brn;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    bout_d  = brn;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            d_q      <= d_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
        end
    end

    assign busy   = (state_q == S_SHIFT);
    assign dvalid = busy;
    assign dbit   = busy & diff;
    assign done   = (state_q == S_DONE);
    assign d      = d_q;
    assign bout   = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: WIDTH=8 and WIDTH=1 instances,
// directed vectors with hand-computed results checked on every done pulse.
module tb_serial_subtractor;

    typedef struct packed {
        logic [7:0] d;
        logic       bo;
    } exp_t;

    logic clk, rst;
    logic start8, busy8, dbit8, dvalid8, bout8, done8;
    logic [7:0] a8, b8, d8;
    logic start1, busy1, dbit1, dvalid1, bout1, done1;
    logic [0:0] a1, b1, d1;

    int total = 0;
    int bad   = 0;
    exp_t q8[$];
    exp_t q1[$];
    logic [7:0] ser8;
    logic       ser1;
    int nb8, nb1;

    serial_subtractor #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .dbit(dbit8), .dvalid(dvalid8), .d(d8),
        .bout(bout8), .done(done8)
    );

    serial_subtractor #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .dbit(dbit1), .dvalid(dvalid1), .d(d1),
        .bout(bout1), .done(done1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string nm);
        total++;
        bad++;
        $display("FAIL %s: done pulse with empty scoreboard at %0t", nm, $time);
    endtask

    // Monitor, WIDTH=8: rebuild the serial stream and compare on done.
    always @(negedge clk) begin
        if (rst) begin
            nb8  = 0;
            ser8 = '0;
        end else begin
            if (!dvalid8) chk("dbit_gated8", {31'd0, dbit8}, 32'd0);
            if (dvalid8) begin
                ser8 = {dbit8, ser8[7:1]};
                nb8++;
            end
            if (done8) begin
                exp_t e;
                chk("busy_in_done8", {30'd0, busy8, dvalid8}, 32'd0);
                if (q8.size() == 0) unexpected("extra_done8");
                else begin
                    e = q8.pop_front();
                    chk("d8", {24'd0, d8}, {24'd0, e.d});
                    chk("bout8", {31'd0, bout8}, {31'd0, e.bo});
                    chk("serial8", {24'd0, ser8}, {24'd0, e.d});
                    chk("nbits8", nb8, 32'd8);
                end
                nb8 = 0;
            end
        end
    end

    // Monitor, WIDTH=1.
    always @(negedge clk) begin
        if (rst) begin
            nb1  = 0;
            ser1 = 1'b0;
        end else begin
            if (!dvalid1) chk("dbit_gated1", {31'd0, dbit1}, 32'd0);
            if (dvalid1) begin
                ser1 = dbit1;
                nb1++;
            end
            if (done1) begin
                exp_t e;
                if (q1.size() == 0) unexpected("extra_done1");
                else begin
                    e = q1.pop_front();
                    chk("d1", {31'd0, d1}, {31'd0, e.d[0]});
                    chk("bout1", {31'd0, bout1}, {31'd0, e.bo});
                    chk("serial1", {31'd0, ser1}, {31'd0, e.d[0]});
                    chk("nbits1", nb1, 32'd1);
                end
                nb1 = 0;
            end
        end
    end

    // Issue one op in the next cycle; returns in the done cycle.
    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] d, input logic bo);
        int n;
        @(negedge clk);
        a8 = a; b8 = b; start8 = 1'b1;
        q8.push_back('{d: d, bo: bo});
        @(negedge clk);
        start8 = 1'b0;
        n = 1;
        while (!done8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency8", n, 32'd9);
    endtask

    task automatic run1(input logic a, input logic b, input logic d, input logic bo);
        @(negedge clk);
        a1 = a; b1 = b; start1 = 1'b1;
        q1.push_back('{d: {7'd0, d}, bo: bo});
        @(negedge clk);
        start1 = 1'b0;
        chk("w1_busy_c1", {30'd0, busy1, done1}, 32'd2);
        @(negedge clk);
        chk("w1_done_c2", {30'd0, busy1, done1}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start1 = 1'b0; a1 = '0; b1 = '0;
        repeat (2) @(negedge clk);
        chk("reset8", {d8, busy8, dbit8, dvalid8, bout8, done8}, 32'd0);
        chk("reset1", {d1, busy1, dbit1, dvalid1, bout1, done1}, 32'd0);
        rst = 1'b0;

        // Basic op and back-to-back earliest starts.
        run8(8'd100, 8'd37, 8'd63, 1'b0);
        run8(8'h00, 8'h01, 8'hFF, 1'b1);
        run8(8'hFF, 8'hFF, 8'h00, 1'b0);

        // Start held high: ops every 10 cycles, one idle cycle after done.
        @(negedge clk);
        a8 = 8'h55; b8 = 8'hAA; start8 = 1'b1;
        repeat (3) q8.push_back('{d: 8'hAB, bo: 1'b1});
        for (int e = 0; e < 30; e++) begin
            @(negedge clk);
            chk("hold_busy", {31'd0, busy8}, ((e % 10) < 8) ? 32'd1 : 32'd0);
            chk("hold_done", {31'd0, done8}, ((e % 10) == 8) ? 32'd1 : 32'd0);
        end
        start8 = 1'b0;

        // Start during SHIFT is ignored and operands are not resampled.
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
        q8.push_back('{d: 8'h0F, bo: 1'b0});
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (14) @(negedge clk);

        // Async reset in SHIFT cycle 3: outputs clear at once, no done.
        a8 = 8'h33; b8 = 8'h11; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("midrst8", {d8, busy8, dbit8, dvalid8, bout8, done8}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        run8(8'd200, 8'd55, 8'd145, 1'b0);

        // WIDTH=1 truth table.
        run1(1'b0, 1'b0, 1'b0, 1'b0);
        run1(1'b1, 1'b0, 1'b1, 1'b0);
        run1(1'b0, 1'b1, 1'b1, 1'b1);
        run1(1'b1, 1'b1, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("q8_drained", q8.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: no finish by %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
